// File: rtl/axi_ddr_pkg.sv
// Shared AXI4 constants, FSM state codes and small helpers for the DDR
// (MIG UI) burst master.
package axi_ddr_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int ID_W   = 4;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_16B    = 3'b100;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [2:0] axi_state_t;

  localparam axi_state_t ST_IDLE = 3'd0;
  localparam axi_state_t ST_AW   = 3'd1;
  localparam axi_state_t ST_W    = 3'd2;
  localparam axi_state_t ST_B    = 3'd3;
  localparam axi_state_t ST_AR   = 3'd4;
  localparam axi_state_t ST_R    = 3'd5;

  // A burst of 16-byte beats stays in one 4 KB page iff the last line index fits in 8 bits.
  function automatic logic crosses_4k(input logic [ADDR_W-1:0] addr, input logic [7:0] len);
    logic [8:0] last_line;
    last_line = {1'b0, addr[11:4]} + {1'b0, len};
    return last_line[8];
  endfunction

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI4 master-side bus (AW/W/B/AR/R channels) between the burst master and
// the DDR controller slave port.
interface axi_burst_master_if;
  import axi_ddr_pkg::*;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master: turns one user command into one
// AW/W/B or AR/R transaction, streaming beats straight through.
module axi_burst_master
  import axi_ddr_pkg::*;
#(
  parameter logic [ID_W-1:0] AXI_ID = 4'h0,
  parameter logic [3:0]      CACHE  = 4'b0011
) (
  input  logic               axi_clk,
  input  logic               axi_reset,

  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [7:0]         cmd_len,

  input  logic [DATA_W-1:0]  wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,

  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               rd_last,
  input  logic               rd_ready,

  output logic               done,
  output logic [1:0]         resp,
  output logic               cmd_err,
  output logic               busy,

  axi_burst_master_if.master m_axi
);

  axi_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        len_reg;
  logic [7:0]        beat_reg;
  logic [1:0]        rmax_reg;
  logic              perr_reg;
  logic [1:0]        resp_reg;
  logic              done_reg;
  logic              cmd_err_reg;

  logic cmd_bad, cmd_accept, cmd_reject;
  logic last_beat, w_fire, r_fire, rlast_bad;

  assign cmd_bad    = crosses_4k(cmd_addr, cmd_len);
  assign cmd_accept = cmd_valid && cmd_ready && !cmd_bad;
  assign cmd_reject = cmd_valid && cmd_ready && cmd_bad;
  assign last_beat  = (beat_reg == len_reg);
  assign w_fire     = (state_reg == ST_W) && wr_valid && m_axi.wready;
  assign r_fire     = (state_reg == ST_R) && m_axi.rvalid && rd_ready;
  // rlast must coincide exactly with the counted final beat.
  assign rlast_bad  = (m_axi.rlast != last_beat);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (cmd_accept)                state_next = cmd_write ? ST_AW : ST_AR;
      ST_AW:   if (m_axi.awready)             state_next = ST_W;
      ST_W:    if (w_fire && last_beat)       state_next = ST_B;
      ST_B:    if (m_axi.bvalid)              state_next = ST_IDLE;
      ST_AR:   if (m_axi.arready)             state_next = ST_R;
      ST_R:    if (r_fire && last_beat)       state_next = ST_IDLE;
      default:                                state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      len_reg     <= '0;
      beat_reg    <= '0;
      rmax_reg    <= RESP_OKAY;
      perr_reg    <= 1'b0;
      resp_reg    <= RESP_OKAY;
      done_reg    <= 1'b0;
      cmd_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      done_reg    <= 1'b0;
      cmd_err_reg <= cmd_reject;

      if (cmd_accept) begin
        addr_reg <= {cmd_addr[ADDR_W-1:4], 4'h0};
        len_reg  <= cmd_len;
        beat_reg <= '0;
        rmax_reg <= RESP_OKAY;
        perr_reg <= 1'b0;
      end

      if (w_fire && !last_beat) begin
        beat_reg <= beat_reg + 8'd1;
      end

      if ((state_reg == ST_B) && m_axi.bvalid) begin
        resp_reg <= m_axi.bresp;
        done_reg <= 1'b1;
      end

      // The burst always ends on the counter; a misplaced rlast only taints resp.
      if (r_fire) begin
        rmax_reg <= resp_max(rmax_reg, m_axi.rresp);
        perr_reg <= perr_reg | rlast_bad;
        if (last_beat) begin
          resp_reg <= (perr_reg || rlast_bad) ? RESP_SLVERR : resp_max(rmax_reg, m_axi.rresp);
          done_reg <= 1'b1;
        end else begin
          beat_reg <= beat_reg + 8'd1;
        end
      end
    end
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign resp      = resp_reg;
  assign cmd_err   = cmd_err_reg;

  assign m_axi.awid    = AXI_ID;
  assign m_axi.awaddr  = addr_reg;
  assign m_axi.awlen   = len_reg;
  assign m_axi.awsize  = SIZE_16B;
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = CACHE;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awqos   = 4'h0;
  assign m_axi.awvalid = (state_reg == ST_AW);

  assign m_axi.wdata   = wr_data;
  assign m_axi.wstrb   = {STRB_W{1'b1}};
  assign m_axi.wlast   = (state_reg == ST_W) && last_beat;
  assign m_axi.wvalid  = (state_reg == ST_W) && wr_valid;
  assign wr_ready      = (state_reg == ST_W) && m_axi.wready;
  assign m_axi.bready  = (state_reg == ST_B);

  assign m_axi.arid    = AXI_ID;
  assign m_axi.araddr  = addr_reg;
  assign m_axi.arlen   = len_reg;
  assign m_axi.arsize  = SIZE_16B;
  assign m_axi.arburst = BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = CACHE;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arqos   = 4'h0;
  assign m_axi.arvalid = (state_reg == ST_AR);

  assign m_axi.rready  = (state_reg == ST_R) && rd_ready;
  assign rd_valid      = (state_reg == ST_R) && m_axi.rvalid;
  assign rd_data       = m_axi.rdata;
  assign rd_last       = (state_reg == ST_R) && last_beat;

  // MIG only ever answers with our own ID, so bid/rid carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi.bid, m_axi.rid, cmd_addr[3:0]};

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master: table-driven directed bursts,
// a mid-burst reset abort, and randomized bursts against a burst-level model.
module tb_axi_burst_master;

  localparam logic [3:0] TB_ID    = 4'h5;
  localparam logic [3:0] TB_CACHE = 4'b0011;
  localparam int         CYC_MAX  = 3000;

  logic         clk;
  logic         axi_reset;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [27:0]  cmd_addr;
  logic [7:0]   cmd_len;
  logic [127:0] wr_data;
  logic         wr_valid, wr_ready;
  logic [127:0] rd_data;
  logic         rd_valid, rd_last, rd_ready;
  logic         done, cmd_err, busy;
  logic [1:0]   resp;

  int n_checks = 0;
  int n_errors = 0;

  axi_burst_master_if m_axi ();

  axi_burst_master #(.AXI_ID(TB_ID), .CACHE(TB_CACHE)) dut (
    .axi_clk(clk), .axi_reset(axi_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .done(done), .resp(resp), .cmd_err(cmd_err), .busy(busy),
    .m_axi(m_axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [27:0] addr;
    logic [7:0]  len;
    int          aw_dly;
    int          rdy;
    int          src;
    int          err_beat;
    logic [1:0]  err_val;
    int          bad_rlast;
    logic [1:0]  bresp;
    logic        exp_err;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp_v);
    end
  endtask

  // Burst-level model: a command is refused when its last 16-byte line leaves the 4 KB page.
  function automatic logic model_err(input logic [27:0] a, input logic [7:0] l);
    int line;
    line = (int'(a) / 16) % 256;
    return (line + int'(l)) > 255;
  endfunction

  function automatic logic [1:0] model_resp(input logic wr, input int len, input int err_beat,
                                            input logic [1:0] err_val, input int bad_rlast,
                                            input logic [1:0] bresp_v);
    if (wr) return bresp_v;
    if (bad_rlast >= 0 && bad_rlast != len) return 2'b10;
    if (err_beat <= len) return err_val;
    return 2'b00;
  endfunction

  task automatic idle_slave();
    wr_valid = 0; rd_ready = 0; wr_data = '0;
    m_axi.awready = 0; m_axi.arready = 0; m_axi.wready = 0;
    m_axi.bvalid = 0; m_axi.bresp = 0; m_axi.bid = TB_ID;
    m_axi.rvalid = 0; m_axi.rdata = '0; m_axi.rresp = 0; m_axi.rlast = 0; m_axi.rid = TB_ID;
  endtask

  task automatic run_txn(input string nm, input logic wr, input logic [27:0] addr,
                         input logic [7:0] len, input int aw_dly, input int rdy, input int src,
                         input int err_beat, input logic [1:0] err_val, input int bad_rlast,
                         input logic [1:0] bresp_v, input logic exp_err, input logic [1:0] exp_resp,
                         input int abort_beat);
    int t, beats, wait_cnt, len_i;
    logic addr_done, fin, aborted;
    logic exp_aw, exp_ar, in_data, exp_wv, exp_rv, exp_rr, exp_br;
    logic [27:0] exp_addr;
    len_i    = int'(len);
    exp_addr = 28'((int'(addr) / 16) * 16);

    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    #1 chk({nm, " cmd_ready"}, cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 0; cmd_addr = 28'($urandom); cmd_len = 8'($urandom);

    if (exp_err) begin
      #1;
      chk({nm, " cmd_err"}, cmd_err, 1'b1);
      chk({nm, " rej awvalid"}, m_axi.awvalid, 1'b0);
      chk({nm, " rej arvalid"}, m_axi.arvalid, 1'b0);
      chk({nm, " rej busy"}, busy, 1'b0);
      chk({nm, " rej cmd_ready"}, cmd_ready, 1'b1);
      @(negedge clk); #1;
      chk({nm, " cmd_err pulse"}, cmd_err, 1'b0);
      chk({nm, " rej awvalid2"}, m_axi.awvalid, 1'b0);
      chk({nm, " rej arvalid2"}, m_axi.arvalid, 1'b0);
      $display("txn %s: wr=%0b addr=%07h len=%0d rejected", nm, wr, addr, len);
      return;
    end

    t = 1; beats = 0; wait_cnt = 0; addr_done = 0; fin = 0; aborted = 0;
    while (!fin && t < CYC_MAX) begin
      if (abort_beat >= 0 && !wr && addr_done && beats == abort_beat) begin
        aborted = 1;
        break;
      end
      m_axi.awready = wr && !addr_done && (wait_cnt >= aw_dly);
      m_axi.arready = !wr && !addr_done && (wait_cnt >= aw_dly);
      wr_valid      = ($urandom_range(99) < src);
      wr_data       = {$urandom(), $urandom(), $urandom(), $urandom()};
      m_axi.wready  = ($urandom_range(99) < rdy);
      m_axi.bvalid  = wr && (beats > len_i) && ($urandom_range(99) < rdy);
      m_axi.bresp   = bresp_v;
      m_axi.rvalid  = ($urandom_range(99) < rdy);
      m_axi.rdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
      m_axi.rresp   = (beats == err_beat) ? err_val : 2'b00;
      m_axi.rlast   = (bad_rlast >= 0) ? (beats == bad_rlast) : (beats == len_i);
      rd_ready      = ($urandom_range(99) < src);
      #1;
      exp_aw  = wr && !addr_done;
      exp_ar  = !wr && !addr_done;
      in_data = addr_done && (beats <= len_i);
      exp_wv  = wr && in_data && wr_valid;
      exp_rv  = !wr && in_data && m_axi.rvalid;
      exp_rr  = !wr && in_data && rd_ready;
      exp_br  = wr && (beats > len_i);
      chk({nm, " awvalid"}, m_axi.awvalid, exp_aw);
      chk({nm, " arvalid"}, m_axi.arvalid, exp_ar);
      chk({nm, " wvalid"}, m_axi.wvalid, exp_wv);
      chk({nm, " wr_ready"}, wr_ready, wr && in_data && m_axi.wready);
      chk({nm, " bready"}, m_axi.bready, exp_br);
      chk({nm, " rd_valid"}, rd_valid, exp_rv);
      chk({nm, " rready"}, m_axi.rready, exp_rr);
      chk({nm, " busy"}, busy, 1'b1);
      chk({nm, " done early"}, done, 1'b0);
      if (exp_aw || exp_ar) begin
        chk({nm, " addr"}, exp_aw ? m_axi.awaddr : m_axi.araddr, exp_addr);
        chk({nm, " len"}, exp_aw ? m_axi.awlen : m_axi.arlen, len);
        chk({nm, " size"}, exp_aw ? m_axi.awsize : m_axi.arsize, 3'b100);
        chk({nm, " burst"}, exp_aw ? m_axi.awburst : m_axi.arburst, 2'b01);
        chk({nm, " id"}, exp_aw ? m_axi.awid : m_axi.arid, TB_ID);
        chk({nm, " cache"}, exp_aw ? m_axi.awcache : m_axi.arcache, TB_CACHE);
        chk({nm, " lock/prot/qos"}, exp_aw ? {m_axi.awlock, m_axi.awprot, m_axi.awqos}
                                           : {m_axi.arlock, m_axi.arprot, m_axi.arqos}, 8'h00);
      end
      if (exp_wv) begin
        chk({nm, " wdata"}, m_axi.wdata, wr_data);
        chk({nm, " wlast"}, m_axi.wlast, beats == len_i);
        chk({nm, " wstrb"}, m_axi.wstrb, 16'hFFFF);
      end
      if (exp_rv) begin
        chk({nm, " rd_data"}, rd_data, m_axi.rdata);
        chk({nm, " rd_last"}, rd_last, beats == len_i);
      end
      if (!addr_done) begin
        if ((exp_aw && m_axi.awready) || (exp_ar && m_axi.arready)) addr_done = 1;
        else wait_cnt++;
      end else if (exp_wv && m_axi.wready) begin
        beats++;
      end else if (exp_rv && rd_ready) begin
        beats++;
        if (beats > len_i) fin = 1;
      end else if (exp_br && m_axi.bvalid) begin
        fin = 1;
      end
      @(negedge clk);
      t++;
    end

    if (aborted) begin
      axi_reset = 1; m_axi.rvalid = 1; rd_ready = 1;
      @(negedge clk); #1;
      chk({nm, " abort rready"}, m_axi.rready, 1'b0);
      chk({nm, " abort rd_valid"}, rd_valid, 1'b0);
      chk({nm, " abort arvalid"}, m_axi.arvalid, 1'b0);
      chk({nm, " abort busy"}, busy, 1'b0);
      chk({nm, " abort done"}, done, 1'b0);
      chk({nm, " abort resp"}, resp, 2'b00);
      axi_reset = 0;
      @(negedge clk); #1;
      chk({nm, " abort cmd_ready"}, cmd_ready, 1'b1);
      chk({nm, " abort idle"}, busy, 1'b0);
      $display("txn %s: read addr=%07h len=%0d reset at beat %0d", nm, addr, len, beats);
    end else begin
      chk({nm, " completed"}, fin, 1'b1);
      #1;
      chk({nm, " done"}, done, 1'b1);
      chk({nm, " resp"}, resp, exp_resp);
      chk({nm, " busy after"}, busy, 1'b0);
      chk({nm, " cmd_ready after"}, cmd_ready, 1'b1);
      if (aw_dly == 0 && rdy == 100 && src == 100)
        chk({nm, " latency"}, 128'(t), 128'(wr ? len_i + 4 : len_i + 3));
      $display("txn %s: wr=%0b addr=%07h len=%0d cycles=%0d resp=%0b", nm, wr, addr, len, t, resp);
      @(negedge clk); #1;
      chk({nm, " done pulse"}, done, 1'b0);
    end
    idle_slave();
  endtask

  initial begin
    logic        wr;
    logic [27:0] addr;
    logic [7:0]  len;
    int          eb, bad, rdy, src;
    logic [1:0]  ev, br;

    vecs[0]  = '{1'b1, 28'h0000100, 8'd3,   0, 100, 100,  -1, 2'd0, -1, 2'd0, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 28'h0000200, 8'd7,   0, 100, 100,   5, 2'd2, -1, 2'd0, 1'b0, 2'd2};
    vecs[2]  = '{1'b1, 28'h0000FF0, 8'd1,   0, 100, 100,  -1, 2'd0, -1, 2'd0, 1'b1, 2'd0};
    vecs[3]  = '{1'b0, 28'h0000FF0, 8'd1,   0, 100, 100,  -1, 2'd0, -1, 2'd0, 1'b1, 2'd0};
    vecs[4]  = '{1'b1, 28'h0000300, 8'd5,   5,  50,  60,  -1, 2'd0, -1, 2'd1, 1'b0, 2'd1};
    vecs[5]  = '{1'b0, 28'h0000400, 8'd3,   0, 100, 100,  -1, 2'd0,  2, 2'd0, 1'b0, 2'd2};
    vecs[6]  = '{1'b1, 28'h0000FF0, 8'd0,   0,  80,  80,  -1, 2'd0, -1, 2'd3, 1'b0, 2'd3};
    vecs[7]  = '{1'b0, 28'h0000000, 8'd255, 0, 100, 100, 255, 2'd1, -1, 2'd0, 1'b0, 2'd1};
    vecs[8]  = '{1'b1, 28'h0000010, 8'd255, 0, 100, 100,  -1, 2'd0, -1, 2'd0, 1'b1, 2'd0};
    vecs[9]  = '{1'b0, 28'h0000500, 8'd4,   0,  60,  80,  -1, 2'd0, -1, 2'd0, 1'b0, 2'd0};
    vecs[10] = '{1'b0, 28'hABCDE5A, 8'd20,  0,  70,  70,   3, 2'd3, -1, 2'd0, 1'b0, 2'd3};

    axi_reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    idle_slave();
    repeat (3) @(negedge clk);
    #1;
    chk("reset cmd_ready", cmd_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset cmd_err", cmd_err, 1'b0);
    chk("reset resp", resp, 2'b00);
    chk("reset valids", {m_axi.awvalid, m_axi.arvalid, m_axi.wvalid, m_axi.bready,
                         m_axi.rready, rd_valid}, 6'b0);
    axi_reset = 0;

    for (int i = 0; i < 11; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].aw_dly,
              vecs[i].rdy, vecs[i].src, vecs[i].err_beat, vecs[i].err_val, vecs[i].bad_rlast,
              vecs[i].bresp, vecs[i].exp_err, vecs[i].exp_resp, -1);

    run_txn("abort", 1'b0, 28'h0000600, 8'd15, 0, 100, 100, -1, 2'd0, -1, 2'd0, 1'b0, 2'd0, 3);
    run_txn("after_abort", 1'b1, 28'h0000700, 8'd2, 0, 100, 100, -1, 2'd0, -1, 2'd0, 1'b0, 2'd0, -1);

    for (int i = 0; i < 24; i++) begin
      wr   = 1'($urandom_range(1));
      len  = 8'($urandom_range(0, 31));
      addr = 28'($urandom);
      if ($urandom_range(3) == 0) addr[11:8] = 4'hF;
      eb   = int'($urandom_range(0, 40));
      ev   = 2'($urandom);
      br   = 2'($urandom);
      bad  = -1;
      if (len > 0 && $urandom_range(3) == 0) bad = int'($urandom_range(0, int'(len) - 1));
      rdy  = int'($urandom_range(40, 100));
      src  = int'($urandom_range(40, 100));
      run_txn($sformatf("rnd%0d", i), wr, addr, len, int'($urandom_range(0, 3)), rdy, src,
              eb, ev, bad, br, model_err(addr, len),
              model_resp(wr, int'(len), eb, ev, bad, br), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
